// File: rtl/vfd_speed_ramp_ctrl.sv
// Speed-ramp controller for the VFD modulation path: ramps cur_freq toward a
// commanded target and advances the phase accumulator on a periodic sample strobe.
module vfd_speed_ramp_ctrl #(
  parameter int                FREQ_W     = 16,
  parameter int                PHASE_W    = 24,
  parameter int                SAMPLE_DIV = 100,
  parameter int                RAMP_DIV   = 10000,
  parameter int                RAMP_STEP  = 4,
  parameter logic [FREQ_W-1:0] FREQ_MAX   = FREQ_W'(50000)
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FREQ_W-1:0]  cmd_freq,
  input  logic               stop_req,
  input  logic               estop,
  output logic [FREQ_W-1:0]  cur_freq,
  output logic [PHASE_W-1:0] phase,
  output logic               sample_stb,
  output logic [2:0]         state,
  output logic               at_speed,
  output logic               busy
);

  localparam int SCW = $clog2(SAMPLE_DIV);
  localparam int RCW = $clog2(RAMP_DIV);
  localparam logic [SCW-1:0]  S_LAST = SCW'(SAMPLE_DIV - 1);
  localparam logic [RCW-1:0]  R_LAST = RCW'(RAMP_DIV - 1);
  localparam logic [FREQ_W:0] STEP_X = (FREQ_W + 1)'(RAMP_STEP);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEL  = 3'd1,
    S_CRUISE = 3'd2,
    S_DECEL  = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [SCW-1:0]      scnt_q, scnt_d;
  logic [RCW-1:0]      rcnt_q, rcnt_d;
  logic                stb_q, stb_d;
  logic [FREQ_W-1:0]   cur_q, cur_d, tgt_q, tgt_d, tgt_new;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [FREQ_W:0]     cur_up;
  logic                s_wrap, ramp_tick, accept;

  assign s_wrap    = (scnt_q == S_LAST);
  assign ramp_tick = (rcnt_q == R_LAST);
  assign scnt_d    = s_wrap ? '0 : scnt_q + 1'b1;
  assign rcnt_d    = ramp_tick ? '0 : rcnt_q + 1'b1;
  assign stb_d     = s_wrap;

  assign cmd_ready = !estop && !stop_req && (state_q != S_STOP);
  assign accept    = cmd_valid && cmd_ready;
  assign tgt_new   = (cmd_freq > FREQ_MAX) ? FREQ_MAX : cmd_freq;
  // One extra bit so the ramp step can never wrap past the word width.
  assign cur_up    = {1'b0, cur_q} + STEP_X;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    phase_d = s_wrap ? phase_q + PHASE_W'(cur_q) : phase_q;
    if (estop) begin
      state_d = S_IDLE;
      cur_d   = '0;
      tgt_d   = '0;
      phase_d = '0;
    end else if (stop_req && (state_q == S_ACCEL || state_q == S_CRUISE ||
                              state_q == S_DECEL)) begin
      state_d = S_STOP;
    end else if (accept) begin
      // A ramp tick landing on an accept is dropped; cur_freq holds.
      tgt_d = tgt_new;
      if (tgt_new > cur_q)      state_d = S_ACCEL;
      else if (tgt_new < cur_q) state_d = S_DECEL;
      else if (tgt_new != '0)   state_d = S_CRUISE;
      else                      state_d = S_IDLE;
    end else if (ramp_tick) begin
      case (state_q)
        S_ACCEL: begin
          if (cur_up >= {1'b0, tgt_q}) begin
            cur_d   = tgt_q;
            state_d = S_CRUISE;
          end else begin
            cur_d = cur_up[FREQ_W-1:0];
          end
        end
        S_DECEL: begin
          if ({1'b0, cur_q} <= {1'b0, tgt_q} + STEP_X) begin
            cur_d   = tgt_q;
            state_d = (tgt_q == '0) ? S_IDLE : S_CRUISE;
          end else begin
            cur_d = cur_q - STEP_X[FREQ_W-1:0];
          end
        end
        S_STOP: begin
          if ({1'b0, cur_q} <= STEP_X) begin
            cur_d   = '0;
            tgt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cur_d = cur_q - STEP_X[FREQ_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      scnt_q  <= '0;
      rcnt_q  <= '0;
      stb_q   <= 1'b0;
      cur_q   <= '0;
      tgt_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      rcnt_q  <= rcnt_d;
      stb_q   <= stb_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      phase_q <= phase_d;
    end
  end

  assign cur_freq   = cur_q;
  assign phase      = phase_q;
  assign sample_stb = stb_q;
  assign state      = state_q;
  assign at_speed   = (state_q == S_CRUISE);
  assign busy       = (state_q == S_ACCEL) || (state_q == S_DECEL) || (state_q == S_STOP);

endmodule

// File: tb/tb_vfd_speed_ramp_ctrl.sv
// Bench for vfd_speed_ramp_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-count based reference model.
module tb_vfd_speed_ramp_ctrl;
  localparam int FW = 8, PW = 8, SDIV = 4, RDIV = 8, STEP = 4, FMAX = 100;

  logic          clk_in, reset, cmd_valid, cmd_ready, stop_req, estop;
  logic          sample_stb, at_speed, busy;
  logic [FW-1:0] cmd_freq, cur_freq;
  logic [PW-1:0] phase;
  logic [2:0]    state;
  int checks = 0, errors = 0;

  vfd_speed_ramp_ctrl #(.FREQ_W(FW), .PHASE_W(PW), .SAMPLE_DIV(SDIV), .RAMP_DIV(RDIV),
    .RAMP_STEP(STEP), .FREQ_MAX(8'd100)) dut (
    .clk_in(clk_in), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_freq(cmd_freq), .stop_req(stop_req), .estop(estop), .cur_freq(cur_freq),
    .phase(phase), .sample_stb(sample_stb), .state(state), .at_speed(at_speed), .busy(busy));

  initial begin
    clk_in = 0;
    forever #5 clk_in = ~clk_in;
  end

  // Reference model: edges counted since reset; strobe/tick from modulo arithmetic.
  int m_cyc, m_cur, m_ph, m_tgt, m_st, m_t;
  bit m_stb;
  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      m_cyc = 0; m_cur = 0; m_ph = 0; m_tgt = 0; m_st = 0; m_stb = 0;
    end else begin
      m_cyc++;
      m_stb = (m_cyc % SDIV) == 0;
      if (m_stb) m_ph = (m_ph + m_cur) % 256;
      if (estop) begin
        m_cur = 0; m_ph = 0; m_tgt = 0; m_st = 0;
      end else if (stop_req && m_st >= 1 && m_st <= 3) begin
        m_st = 4;
      end else if (cmd_valid && !stop_req && m_st != 4) begin
        m_t   = (int'(cmd_freq) > FMAX) ? FMAX : int'(cmd_freq);
        m_st  = (m_t > m_cur) ? 1 : (m_t < m_cur) ? 3 : (m_t != 0) ? 2 : 0;
        m_tgt = m_t;
      end else if ((m_cyc % RDIV) == 0) begin
        if (m_st == 1) begin
          m_cur = (m_cur + STEP < m_tgt) ? m_cur + STEP : m_tgt;
          if (m_cur == m_tgt) m_st = 2;
        end else if (m_st == 3) begin
          m_cur = (m_cur - STEP > m_tgt) ? m_cur - STEP : m_tgt;
          if (m_cur == m_tgt) m_st = (m_tgt == 0) ? 0 : 2;
        end else if (m_st == 4) begin
          m_cur = (m_cur - STEP > 0) ? m_cur - STEP : 0;
          if (m_cur == 0) begin m_st = 0; m_tgt = 0; end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset();
    cmd_valid = 0; stop_req = 0; estop = 0; cmd_freq = 0;
    reset = 1; #2; reset = 0;
  endtask

  task automatic send(input int f);
    cmd_freq = 8'(f); cmd_valid = 1; step(); cmd_valid = 0;
  endtask

  task automatic test_reset();
    logic [21:0] got;
    cmd_valid = 0; stop_req = 0; estop = 0; cmd_freq = 0;
    reset = 1; #1;
    got = {cur_freq, phase, state, sample_stb, at_speed, busy, cmd_ready};
    checks++;
    if (got !== 22'h1) begin errors++; $display("FAIL reset_outputs got %h exp %h", got, 22'h1); end
    #1 reset = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      checks++;
      if (sample_stb !== ((e % SDIV) == 0) || phase !== 0 || state !== 0) begin
        errors++;
        $display("FAIL idle_strobe edge %0d got stb=%b ph=%0d st=%0d exp stb=%b ph=0 st=0",
                 e, sample_stb, phase, state, (e % SDIV) == 0);
      end
    end
  endtask

  task automatic test_accel();
    int seen[$];
    int exp_a[5] = '{4, 8, 12, 16, 20};
    logic [FW-1:0] prev;
    do_reset(); step();
    send(20);
    checks++;
    if (state !== 1 || cur_freq !== 0 || busy !== 1) begin
      errors++; $display("FAIL accel_enter got st=%0d cur=%0d busy=%b exp 1 0 1", state, cur_freq, busy);
    end
    for (int i = 0; i < 60 && state != 2; i++) begin
      prev = cur_freq; step();
      if (cur_freq != prev) seen.push_back(int'(cur_freq));
    end
    checks++;
    if (seen.size() != 5) begin errors++; $display("FAIL accel_steps got %0d exp 5", seen.size()); end
    else foreach (exp_a[k]) begin
      checks++;
      if (seen[k] != exp_a[k]) begin errors++; $display("FAIL accel_val[%0d] got %0d exp %0d", k, seen[k], exp_a[k]); end
    end
    checks++;
    if (state !== 2 || at_speed !== 1 || busy !== 0) begin
      errors++; $display("FAIL accel_cruise got st=%0d at=%b busy=%b exp 2 1 0", state, at_speed, busy);
    end
  endtask

  task automatic test_decel();
    int seen[$];
    int exp_d[3] = '{16, 12, 10};
    logic [FW-1:0] prev;
    send(10);
    checks++;
    if (state !== 3) begin errors++; $display("FAIL decel_enter got %0d exp 3", state); end
    for (int i = 0; i < 40 && state == 3; i++) begin
      prev = cur_freq; step();
      if (cur_freq != prev) seen.push_back(int'(cur_freq));
    end
    checks++;
    if (seen.size() != 3) begin errors++; $display("FAIL decel_steps got %0d exp 3", seen.size()); end
    else foreach (exp_d[k]) begin
      checks++;
      if (seen[k] != exp_d[k]) begin errors++; $display("FAIL decel_val[%0d] got %0d exp %0d", k, seen[k], exp_d[k]); end
    end
    checks++;
    if (state !== 2 || cur_freq !== 10) begin errors++; $display("FAIL decel_cruise got st=%0d cur=%0d exp 2 10", state, cur_freq); end
    send(250);
    checks++;
    if (state !== 1) begin errors++; $display("FAIL clamp_accel got %0d exp 1", state); end
    for (int i = 0; i < 260 && state != 2; i++) step();
    checks++;
    if (state !== 2 || cur_freq !== 8'(FMAX)) begin
      errors++; $display("FAIL clamp_target got st=%0d cur=%0d exp 2 %0d", state, cur_freq, FMAX);
    end
  endtask

  task automatic test_phase_wrap();
    int p0, n;
    for (int i = 0; i < SDIV && !sample_stb; i++) step();
    p0 = int'(phase);
    for (int i = 1; i <= 16; i++) begin
      step();
      n = i / SDIV;
      checks++;
      if (sample_stb !== ((i % SDIV) == 0) || int'(phase) != (p0 + 100 * n) % 256) begin
        errors++;
        $display("FAIL phase_wrap i=%0d got stb=%b ph=%0d exp stb=%b ph=%0d",
                 i, sample_stb, phase, (i % SDIV) == 0, (p0 + 100 * n) % 256);
      end
    end
    for (int i = 0; i < RDIV && (m_cyc % RDIV) != RDIV - 1; i++) step();
    send(50);
    checks++;
    if (cur_freq !== 100 || state !== 3) begin
      errors++; $display("FAIL tick_on_accept got cur=%0d st=%0d exp 100 3", cur_freq, state);
    end
    repeat (RDIV) step();
    checks++;
    if (cur_freq !== 96) begin errors++; $display("FAIL tick_after_accept got %0d exp 96", cur_freq); end
  endtask

  task automatic test_stop();
    int seen[$];
    int exp_s[5] = '{16, 12, 8, 4, 0};
    logic [FW-1:0] prev;
    bit bad_state = 0;
    do_reset(); step();
    send(20);
    for (int i = 0; i < 60 && state != 2; i++) step();
    stop_req = 1; cmd_valid = 1; cmd_freq = 80; #1;
    checks++;
    if (cmd_ready !== 0) begin errors++; $display("FAIL stop_ready got %b exp 0", cmd_ready); end
    step();
    checks++;
    if (state !== 4 || cmd_ready !== 0) begin
      errors++; $display("FAIL stop_enter got st=%0d rdy=%b exp 4 0", state, cmd_ready);
    end
    for (int i = 0; i < 60 && state == 4; i++) begin
      prev = cur_freq; step();
      if (cur_freq != prev) seen.push_back(int'(cur_freq));
      if (state != 4 && state != 0) bad_state = 1;
    end
    checks++;
    if (seen.size() != 5 || bad_state) begin
      errors++; $display("FAIL stop_steps got %0d bad=%b exp 5 0", seen.size(), bad_state);
    end else foreach (exp_s[k]) begin
      checks++;
      if (seen[k] != exp_s[k]) begin errors++; $display("FAIL stop_val[%0d] got %0d exp %0d", k, seen[k], exp_s[k]); end
    end
    repeat (3) step();
    checks++;
    if (state !== 0 || cur_freq !== 0) begin
      errors++; $display("FAIL stop_idle_hold got st=%0d cur=%0d exp 0 0", state, cur_freq);
    end
    stop_req = 0; cmd_valid = 0;
  endtask

  task automatic test_estop();
    do_reset(); step();
    send(20);
    for (int i = 0; i < 40 && cur_freq != 12; i++) step();
    checks++;
    if (cur_freq !== 12 || state !== 1) begin
      errors++; $display("FAIL estop_setup got cur=%0d st=%0d exp 12 1", cur_freq, state);
    end
    estop = 1; #1;
    checks++;
    if (cmd_ready !== 0) begin errors++; $display("FAIL estop_ready got %b exp 0", cmd_ready); end
    step();
    checks++;
    if (cur_freq !== 0 || phase !== 0 || state !== 0) begin
      errors++; $display("FAIL estop_stop got cur=%0d ph=%0d st=%0d exp 0 0 0", cur_freq, phase, state);
    end
    cmd_valid = 1; cmd_freq = 30;
    repeat (3) step();
    checks++;
    if (state !== 0 || cmd_ready !== 0 || cur_freq !== 0) begin
      errors++; $display("FAIL estop_hold got st=%0d rdy=%b cur=%0d exp 0 0 0", state, cmd_ready, cur_freq);
    end
    estop = 0; cmd_valid = 0; #1;
    checks++;
    if (cmd_ready !== 1) begin errors++; $display("FAIL estop_release got %b exp 1", cmd_ready); end
  endtask

  task automatic test_random();
    logic [21:0] got, exp;
    bit exp_rdy;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin reset = 1; #1 reset = 0; end
      cmd_valid = ($urandom_range(0, 39) == 0);
      cmd_freq  = 8'($urandom_range(0, 140));
      if ($urandom_range(0, 199) == 0) stop_req = ~stop_req;
      estop = ($urandom_range(0, 299) == 0);
      #1;
      exp_rdy = !estop && !stop_req && m_st != 4;
      checks++;
      if (cmd_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, cmd_ready, exp_rdy);
      end
      step();
      got = {cur_freq, phase, state, sample_stb, at_speed, busy};
      exp = {8'(m_cur), 8'(m_ph), 3'(m_st), m_stb, m_st == 2, m_st == 1 || m_st == 3 || m_st == 4};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rnd_outputs cyc %0d got %h exp %h", i, got, exp);
      end
    end
    stop_req = 0; estop = 0; cmd_valid = 0;
  endtask

  initial begin
    reset = 1; cmd_valid = 0; stop_req = 0; estop = 0; cmd_freq = 0;
    test_reset();
    test_accel();
    test_decel();
    test_phase_wrap();
    test_stop();
    test_estop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
